rescale_line_buffer: RTL and testbench
======================================

// Module: rescale_line_buffer
// PURPOSE
//  Parametrised AXI-Stream line buffer for the rescale datapath. Accepts RGB888 beats, converts to RGB565,
//  discards a programmable number of rows before each kept row, and stores kept rows in a circular store.
//  Presents a 2x2 neighbour window (top row / next row, col / col+1) to the rescale interpolator.
//  Adds TREADY back-pressure, multi-row circular storage and a registered read port.
// PARAMETERS
//  ROW_WORDS  8   pixels per row, >=2
//  NUM_ROWS   3   row slots in circular store, >=2; 3 allows filling while a window is in use
//  COL_W      11  width of rd_col
//  SKIP_W     9   width of row_skip
// PORTS
//  clock          in   1          clock
//  resetn         in   1          synchronous, active-low reset
//  s_axis_tdata   in   32         pixel: R=[23:16], G=[15:8], B=[7:0]
//  s_axis_tvalid  in   1          beat valid
//  s_axis_tlast   in   1          last beat of a row
//  s_axis_tready  out  1          beat accepted when tvalid & tready
//  row_skip       in   SKIP_W     rows to discard before each kept row; sampled in LOAD
//  win_valid      out  1          >=2 rows stored; window readable
//  win_advance    in   1          release oldest row; ignored when !win_valid
//  rd_req         in   1          window read request; ignored when !win_valid
//  rd_col         in   COL_W      left column of 2x2 window
//  rd_valid       out  1          nb0..nb3 valid, one cycle after accepted rd_req
//  nb0..nb3       out  16 each    top[c], top[c+1], next[c], next[c+1]
//  err_tlast      out  1          sticky: tlast not on word ROW_WORDS-1
// BEHAVIOUR
//  Reset: s_axis_tready=0, win_valid=0, rd_valid=0, nb0..3=0, err_tlast=0, rows_stored=0, slot pointers=0,
//   state=LOAD. Storage is not cleared; rows are invisible until committed.
//  Conversion: pix565 = {d[23:19], d[15:10], d[7:3]}.
//  Write FSM:
//   LOAD   tready=0. If rows_stored==NUM_ROWS, stay. Else skip_cnt<=row_skip and go to SKIP if row_skip!=0,
//          else go to FILL with col=0.
//   SKIP   tready=1. Accepted beats are dropped. Accepted tlast decrements skip_cnt; at 1->0 go to FILL, col=0.
//   FILL   tready=1. Accepted beat writes slot[wr_slot][col] and increments col.
//          Accepted tlast with col<ROW_WORDS-1: set err_tlast; commit the row (unwritten columns stale); go to LOAD.
//          Beat at col==ROW_WORDS-1: commit the row. With tlast, go to LOAD; without tlast, set err_tlast and go to DRAIN.
//   DRAIN  tready=1. Drop beats until accepted tlast, then go to LOAD.
//   Commit: wr_slot <= (wr_slot+1) mod NUM_ROWS; rows_stored++.
//  Window: top=rd_slot, next=(rd_slot+1) mod NUM_ROWS. win_valid = rows_stored>=2 (combinational from register).
//   Accepted win_advance: rd_slot <= (rd_slot+1) mod NUM_ROWS; rows_stored--.
//   Commit and win_advance in the same cycle: rows_stored unchanged, both pointers move.
//  Read: accepted rd_req -> rd_valid=1 next cycle with nb registered; otherwise rd_valid=0 next cycle and nb holds.
//   c = min(rd_col, ROW_WORDS-1); c+1 is clamped to ROW_WORDS-1 (edge replicate).
//   Read and win_advance in the same cycle: the read uses pre-advance slots.
//   Read of a slot being written in the same cycle is impossible, because wr_slot is never top or next while win_valid.
//  Mid-operation reset: returns to reset state on the next edge. Any partial row is lost; err_tlast is cleared.
//  Throughput: 1 beat/cycle in SKIP, FILL and DRAIN. LOAD adds 1 bubble per kept row.
// STRUCTURE
//  rescale_pkg: rgb888_to_565() function, PIX565_W=16, wr_state_t enum {LOAD, SKIP, FILL, DRAIN}.
//  Sub-module rescale_row_store: NUM_ROWS*ROW_WORDS x 16 array with 1 write port and 4 registered read ports.
//  Top level holds the write FSM, pointers, rows_stored, clamp logic and err_tlast.
// TESTING
//  1. row_skip=0, send 2 rows of 8 beats, data=0x00F8FCF8 pattern -> win_valid after 2nd tlast+1; rd_col=0 gives nb0=0xFFFF.
//  2. row_skip=2, send 6 rows with row index in data -> kept rows are 2 and 5; tready=0 in each LOAD cycle.
//  3. NUM_ROWS=3, fill 3 rows with no advance -> tready=0 (LOAD holds); pulse win_advance -> next row accepted.
//  4. rd_col=7 with ROW_WORDS=8 -> nb1==nb0 and nb3==nb2; rd_col=20 -> same as rd_col=7.
//  5. tlast on beat 5 -> err_tlast=1, row committed; 10 beats without tlast -> err_tlast=1, beats 9..10 dropped.
//  6. Commit+advance in the same cycle keeps rows_stored; reset in mid-FILL -> tready=0, win_valid=0 next cycle.

Source files
------------

// File: rtl/rescale_pkg.sv
// Shared types and helpers for the rescale line buffer.
package rescale_pkg;

  localparam int PIX565_W = 16;

  // Write-side FSM states
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SKIP  = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } wr_state_t;

  // Truncate an RGB888 beat (R=[23:16], G=[15:8], B=[7:0]) to RGB565.
  function automatic logic [PIX565_W-1:0] rgb888_to_565(input logic [31:0] d);
    return {d[23:19], d[15:10], d[7:3]};
  endfunction

endpackage

// File: rtl/rescale_line_buffer_if.sv
// AXI-Stream pixel beat bundle feeding the rescale line buffer.
interface rescale_line_buffer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rescale_row_store.sv
// Circular row store: one write port, four registered read ports forming a 2x2 window.
module rescale_row_store
  import rescale_pkg::*;
#(
  parameter int ROW_WORDS = 8,
  parameter int NUM_ROWS  = 3,
  localparam int SLOT_W   = $clog2(NUM_ROWS),
  localparam int CIDX_W   = $clog2(ROW_WORDS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [SLOT_W-1:0]   wr_slot,
  input  logic [CIDX_W-1:0]   wr_col,
  input  logic [PIX565_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [SLOT_W-1:0]   top_slot,
  input  logic [SLOT_W-1:0]   next_slot,
  input  logic [CIDX_W-1:0]   col_a,
  input  logic [CIDX_W-1:0]   col_b,
  output logic [PIX565_W-1:0] nb0,
  output logic [PIX565_W-1:0] nb1,
  output logic [PIX565_W-1:0] nb2,
  output logic [PIX565_W-1:0] nb3
);

  logic [PIX565_W-1:0] mem_r [NUM_ROWS][ROW_WORDS];

  // Pixel storage; never cleared, rows only become visible once committed
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_slot][wr_col] <= wr_data;
    end
  end

  // Registered window read; outputs hold when no read is accepted
  always_ff @(posedge clock) begin
    if (!resetn) begin
      nb0 <= {PIX565_W{1'b0}};
      nb1 <= {PIX565_W{1'b0}};
      nb2 <= {PIX565_W{1'b0}};
      nb3 <= {PIX565_W{1'b0}};
    end else if (rd_en) begin
      nb0 <= mem_r[top_slot][col_a];
      nb1 <= mem_r[top_slot][col_b];
      nb2 <= mem_r[next_slot][col_a];
      nb3 <= mem_r[next_slot][col_b];
    end
  end

endmodule

// File: rtl/rescale_line_buffer.sv
// Line buffer for the rescale datapath: RGB888 in, row skipping, circular
// multi-row storage and a registered 2x2 neighbour window out.
module rescale_line_buffer
  import rescale_pkg::*;
#(
  parameter int ROW_WORDS = 8,
  parameter int NUM_ROWS  = 3,
  parameter int COL_W     = 11,
  parameter int SKIP_W    = 9
) (
  input  logic                  clock,
  input  logic                  resetn,
  rescale_line_buffer_if.slave  s_axis,
  input  logic [SKIP_W-1:0]     row_skip,
  output logic                  win_valid,
  input  logic                  win_advance,
  input  logic                  rd_req,
  input  logic [COL_W-1:0]      rd_col,
  output logic                  rd_valid,
  output logic [PIX565_W-1:0]   nb0,
  output logic [PIX565_W-1:0]   nb1,
  output logic [PIX565_W-1:0]   nb2,
  output logic [PIX565_W-1:0]   nb3,
  output logic                  err_tlast
);

  localparam int SLOT_W = $clog2(NUM_ROWS);
  localparam int CIDX_W = $clog2(ROW_WORDS);
  localparam int CNT_W  = $clog2(NUM_ROWS + 1);
  localparam logic [CIDX_W-1:0] LAST_COL  = CIDX_W'(ROW_WORDS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_ROWS);

  wr_state_t           state_r, state_s;
  logic [CIDX_W-1:0]   col_r;
  logic [SKIP_W-1:0]   skip_cnt_r;
  logic [SLOT_W-1:0]   wr_slot_r, rd_slot_r, next_slot_s;
  logic [CNT_W-1:0]    rows_stored_r;
  logic                accept_s, advance_s, rd_accept_s;
  logic                wr_en_s, commit_s, set_err_s, col_clr_s, skip_load_s, skip_dec_s;
  logic [CIDX_W-1:0]   col_a_s, col_b_s;
  logic                unused_tdata_s;

  // Wrap a slot pointer around the circular store.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    if (s == LAST_SLOT) begin
      return {SLOT_W{1'b0}};
    end else begin
      return s + SLOT_W'(1);
    end
  endfunction

  assign s_axis.tready  = (state_r != LOAD);
  assign accept_s       = s_axis.tvalid & s_axis.tready;
  assign win_valid      = (rows_stored_r >= CNT_W'(2));
  assign advance_s      = win_advance & win_valid;
  assign rd_accept_s    = rd_req & win_valid;
  assign next_slot_s    = slot_inc(rd_slot_r);
  assign unused_tdata_s = ^s_axis.tdata[31:24];

  // Write FSM state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Write FSM next state and per-beat control strobes
  always_comb begin
    state_s     = state_r;
    wr_en_s     = 1'b0;
    commit_s    = 1'b0;
    set_err_s   = 1'b0;
    col_clr_s   = 1'b0;
    skip_load_s = 1'b0;
    skip_dec_s  = 1'b0;
    case (state_r)
      LOAD: begin
        if (rows_stored_r != FULL_CNT) begin
          skip_load_s = 1'b1;
          col_clr_s   = 1'b1;
          state_s     = (row_skip != {SKIP_W{1'b0}}) ? SKIP : FILL;
        end else begin
          state_s = LOAD;
        end
      end
      SKIP: begin
        if (accept_s && s_axis.tlast) begin
          skip_dec_s = 1'b1;
          if (skip_cnt_r == SKIP_W'(1)) begin
            col_clr_s = 1'b1;
            state_s   = FILL;
          end else begin
            state_s = SKIP;
          end
        end else begin
          state_s = SKIP;
        end
      end
      FILL: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          if (col_r == LAST_COL) begin
            commit_s = 1'b1;
            if (s_axis.tlast) begin
              state_s = LOAD;
            end else begin
              set_err_s = 1'b1;
              state_s   = DRAIN;
            end
          end else if (s_axis.tlast) begin
            // Short row: keep what arrived, remaining columns stay stale
            commit_s  = 1'b1;
            set_err_s = 1'b1;
            state_s   = LOAD;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        if (accept_s && s_axis.tlast) begin
          state_s = LOAD;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // Clamp the window columns to the row, replicating the right edge
  always_comb begin
    col_a_s = LAST_COL;
    col_b_s = LAST_COL;
    if (rd_col >= COL_W'(ROW_WORDS - 1)) begin
      col_a_s = LAST_COL;
    end else begin
      col_a_s = rd_col[CIDX_W-1:0];
    end
    if (col_a_s == LAST_COL) begin
      col_b_s = LAST_COL;
    end else begin
      col_b_s = col_a_s + CIDX_W'(1);
    end
  end

  // Column/skip counters, slot pointers, occupancy, sticky error and read strobe
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_r         <= {CIDX_W{1'b0}};
      skip_cnt_r    <= {SKIP_W{1'b0}};
      wr_slot_r     <= {SLOT_W{1'b0}};
      rd_slot_r     <= {SLOT_W{1'b0}};
      rows_stored_r <= {CNT_W{1'b0}};
      err_tlast     <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      if (col_clr_s) begin
        col_r <= {CIDX_W{1'b0}};
      end else if (wr_en_s) begin
        col_r <= col_r + CIDX_W'(1);
      end
      if (skip_load_s) begin
        skip_cnt_r <= row_skip;
      end else if (skip_dec_s) begin
        skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
      end
      if (commit_s) begin
        wr_slot_r <= slot_inc(wr_slot_r);
      end
      if (advance_s) begin
        rd_slot_r <= next_slot_s;
      end
      if (commit_s && !advance_s) begin
        rows_stored_r <= rows_stored_r + CNT_W'(1);
      end else if (advance_s && !commit_s) begin
        rows_stored_r <= rows_stored_r - CNT_W'(1);
      end
      if (set_err_s) begin
        err_tlast <= 1'b1;
      end
      rd_valid <= rd_accept_s;
    end
  end

  rescale_row_store #(
    .ROW_WORDS (ROW_WORDS),
    .NUM_ROWS  (NUM_ROWS)
  ) u_store (
    .clock     (clock),
    .resetn    (resetn),
    .wr_en     (wr_en_s),
    .wr_slot   (wr_slot_r),
    .wr_col    (col_r),
    .wr_data   (rgb888_to_565(s_axis.tdata)),
    .rd_en     (rd_accept_s),
    .top_slot  (rd_slot_r),
    .next_slot (next_slot_s),
    .col_a     (col_a_s),
    .col_b     (col_b_s),
    .nb0       (nb0),
    .nb1       (nb1),
    .nb2       (nb2),
    .nb3       (nb3)
  );

endmodule

// File: tb/tb_rescale_line_buffer.sv
// Scoreboard bench for rescale_line_buffer: stimulus pushes expected windows,
// a monitor pops and compares whenever rd_valid is presented.
module tb_rescale_line_buffer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  row_skip = 9'd0;
  logic        win_valid;
  logic        win_advance = 1'b0;
  logic        rd_req = 1'b0;
  logic [10:0] rd_col = 11'd0;
  logic        rd_valid;
  logic [15:0] nb0, nb1, nb2, nb3;
  logic        err_tlast;

  int          tests = 0;
  int          fails = 0;
  bit          done = 1'b0;
  logic [63:0] exp_q [$];

  rescale_line_buffer_if axis ();

  rescale_line_buffer #(
    .ROW_WORDS (8),
    .NUM_ROWS  (3),
    .COL_W     (11),
    .SKIP_W    (9)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .s_axis      (axis),
    .row_skip    (row_skip),
    .win_valid   (win_valid),
    .win_advance (win_advance),
    .rd_req      (rd_req),
    .rd_col      (rd_col),
    .rd_valid    (rd_valid),
    .nb0         (nb0),
    .nb1         (nb1),
    .nb2         (nb2),
    .nb3         (nb3),
    .err_tlast   (err_tlast)
  );

  always #5 clock = ~clock;

  // Test pixel: R = tag<<3, G = col<<2, B = 0, so RGB565 = tag<<11 | col<<5
  function automatic logic [31:0] pd(input int t, input int c);
    return {8'h00, 8'(t * 8), 8'(c * 4), 8'h00};
  endfunction

  function automatic logic [15:0] ex(input int t, input int c);
    return 16'(t * 2048 + c * 32);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic adv);
    int n;
    n = 0;
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    axis.tlast  = last;
    win_advance = adv;
    @(negedge clock);
    while (axis.tready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (axis.tready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tready_timeout: tready %b, required 1", axis.tready);
    end
    @(posedge clock);
    #1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    win_advance = 1'b0;
  endtask

  task automatic rd(input int col, input bit adv, input bit expv,
                    input logic [15:0] e0, input logic [15:0] e1,
                    input logic [15:0] e2, input logic [15:0] e3);
    rd_req      = 1'b1;
    rd_col      = 11'(col);
    win_advance = adv;
    if (expv) exp_q.push_back({e0, e1, e2, e3});
    @(posedge clock);
    #1;
    rd_req      = 1'b0;
    win_advance = 1'b0;
  endtask

  task automatic adv1();
    win_advance = 1'b1;
    @(posedge clock);
    #1;
    win_advance = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axis.tdata  = 32'd0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    fork
      begin : stim
        // Reset state
        cyc(3);
        check("rst_tready", 64'(axis.tready), 64'd0);
        check("rst_win_valid", 64'(win_valid), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_err_tlast", 64'(err_tlast), 64'd0);
        check("rst_nb", {nb0, nb1, nb2, nb3}, 64'd0);
        resetn = 1'b1;

        // Two full rows, no skipping
        for (int c = 0; c < 8; c++) beat(32'h00F8FCF8, c == 7, 1'b0);
        check("one_row_no_window", 64'(win_valid), 64'd0);
        beat(32'h00123456, 1'b0, 1'b0);
        for (int c = 1; c < 8; c++) beat(pd(1, c), c == 7, 1'b0);
        check("two_rows_window", 64'(win_valid), 64'd1);
        check("load_bubble", 64'(axis.tready), 64'd0);
        rd(0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h11AA, ex(1, 1));
        rd(3, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, ex(1, 3), ex(1, 4));

        // Fill the third slot; store full so LOAD holds
        for (int c = 0; c < 8; c++) beat(pd(2, c), c == 7, 1'b0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("full_hold_tready", 64'(axis.tready), 64'd0);
        end
        @(posedge clock);
        #1;
        rd(7, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, ex(1, 7), ex(1, 7));
        rd(20, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, ex(1, 7), ex(1, 7));
        row_skip = 9'd2;
        // Read together with advance uses the pre-advance window
        rd(0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h11AA, ex(1, 1));
        rd(7, 1'b0, 1'b1, ex(1, 7), ex(1, 7), ex(2, 7), ex(2, 7));
        rd(20, 1'b0, 1'b1, ex(1, 7), ex(1, 7), ex(2, 7), ex(2, 7));
        rd(5, 1'b0, 1'b1, ex(1, 5), ex(1, 6), ex(2, 5), ex(2, 6));
        adv1();
        check("one_row_left_no_window", 64'(win_valid), 64'd0);
        rd(3, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        cyc(2);

        // Skip two rows before each kept row: kept tags 10 and 13
        for (int k = 0; k < 6; k++) begin
          for (int c = 0; c < 8; c++) beat(pd(8 + k, c), c == 7, 1'b0);
          if (k == 1) check("skip_into_fill", 64'(axis.tready), 64'd1);
          if (k == 2) begin
            check("kept_row_load", 64'(axis.tready), 64'd0);
            rd(1, 1'b0, 1'b1, ex(2, 1), ex(2, 2), ex(10, 1), ex(10, 2));
          end
        end
        check("full_after_skip", 64'(axis.tready), 64'd0);
        row_skip = 9'd0;
        adv1();
        rd(6, 1'b0, 1'b1, ex(10, 6), ex(10, 7), ex(13, 6), ex(13, 7));

        // Commit and advance on the same edge
        for (int c = 0; c < 8; c++) beat(pd(20, c), c == 7, c == 7);
        check("commit_adv_window", 64'(win_valid), 64'd1);
        rd(0, 1'b0, 1'b1, ex(13, 0), ex(13, 1), ex(20, 0), ex(20, 1));
        adv1();
        check("commit_adv_count", 64'(win_valid), 64'd0);

        // Short row: tlast on column 5
        for (int c = 0; c < 6; c++) beat(pd(24, c), c == 5, 1'b0);
        check("short_row_err", 64'(err_tlast), 64'd1);
        check("short_row_load", 64'(axis.tready), 64'd0);
        check("short_row_commit", 64'(win_valid), 64'd1);
        rd(4, 1'b0, 1'b1, ex(20, 4), ex(20, 5), ex(24, 4), ex(24, 5));
        rd(6, 1'b0, 1'b1, ex(20, 6), ex(20, 7), ex(10, 6), ex(10, 7));

        // Reset in the middle of a row
        for (int c = 0; c < 3; c++) beat(pd(26, c), 1'b0, 1'b0);
        resetn = 1'b0;
        cyc(1);
        check("midrst_tready", 64'(axis.tready), 64'd0);
        check("midrst_win_valid", 64'(win_valid), 64'd0);
        check("midrst_err_tlast", 64'(err_tlast), 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        resetn = 1'b1;

        // Overlong row: 10 beats without tlast, then a closing tlast beat
        for (int c = 0; c < 11; c++) begin
          beat(pd((c < 8) ? 28 : 30, c), c == 10, 1'b0);
          if (c == 7) check("overrun_drain_ready", 64'(axis.tready), 64'd1);
        end
        check("overrun_err", 64'(err_tlast), 64'd1);
        check("drain_exit_load", 64'(axis.tready), 64'd0);
        check("overrun_one_row", 64'(win_valid), 64'd0);
        for (int c = 0; c < 8; c++) beat(pd(4, c), c == 7, 1'b0);
        rd(0, 1'b0, 1'b1, ex(28, 0), ex(28, 1), ex(4, 0), ex(4, 1));
        rd(7, 1'b0, 1'b1, ex(28, 7), ex(28, 7), ex(4, 7), ex(4, 7));
        cyc(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
      end
      begin : mon
        logic [63:0] ev;
        while (!done) begin
          @(negedge clock);
          if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL spurious_rd_valid: got rd_valid 1, required 0");
            end else begin
              ev = exp_q.pop_front();
              check("window", {nb0, nb1, nb2, nb3}, ev);
            end
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
